ex_stage_pipe: RTL and testbench
================================

Name: ex_stage_pipe

Overview:
- Parametrised execute stage for the pipelined core; sits between decode and memory stages.
- Replaces the ad-hoc stall-flag EX with a valid/ready handshake on both sides and a registered output.
- Computes ADD/SUB in a single cycle and MUL in a fixed MUL_LAT-cycle pipelined multiplier.
- Resolves BEQ and supports a flush from the branch/hazard unit.

Parameters:
DATA_W, 32, operand/result width
MUL_LAT, 3, MUL latency in cycles from accept to out_valid (>=2)
FUNCT_W, 6, R-type funct field width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
in_valid  in  1  decode presents an instruction
in_ready  out  1  stage accepts this cycle
rs  in  DATA_W  operand 1
rt  in  DATA_W  operand 2 (register)
imm  in  DATA_W  sign-extended immediate
alu_src  in  1  0: op2=rt, 1: op2=imm
alu_op  in  2  00 LW/SW/ADDI, 01 BEQ, 10 R-type
funct  in  FUNCT_W  R-type function: 0 ADD, 1 SUB, 2 MUL
branch  in  1  instruction is a branch
pc  in  DATA_W  PC of the instruction
flush  in  1  kill in-flight and pending output
out_valid  out  1  result registered and valid
out_ready  in  1  downstream accepts
result  out  DATA_W  ALU result
zero  out  1  op1 == op2
branch_taken  out  1  branch && zero
branch_target  out  DATA_W  pc + (imm << 2), modulo 2^DATA_W

Behaviour:
- Reset (reset=0, async): state=IDLE, out_valid=0, result=0, zero=0, branch_taken=0, branch_target=0, multiplier counter=0. in_ready=0 while reset is asserted.
- Accept condition: in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- Operand select: op2 = alu_src ? imm : rt.
- Exception: alu_op 00 forces op2=imm, so LW/SW address = rs + imm.
- Control decode:
  - alu_op 00: ADD.
  - alu_op 01: SUB.
  - alu_op 10: funct 0 ADD, 1 SUB, 2 MUL; any other funct gives result 0 and completes as single-cycle.
  - alu_op 11: result 0, single-cycle.
- Arithmetic:
  - ADD/SUB wrap modulo 2^DATA_W.
  - MUL keeps the low DATA_W bits of the unsigned product.
  - zero compares op1 and op2 (not the result).
- State IDLE:
  - Single-cycle op accepted: result, zero, branch_taken and branch_target are registered; out_valid=1 next cycle (latency 1).
  - MUL accepted: go to MUL_BUSY and load counter=MUL_LAT-1.
- State MUL_BUSY:
  - in_ready=0; the counter decrements each cycle.
  - At count 1, register the product and return to IDLE; out_valid=1 MUL_LAT cycles after accept.
  - The MUL path's zero and branch fields are captured at accept and presented with the result.
- Backpressure: while out_valid && !out_ready, all outputs hold stable and no new accept occurs. Output retires on out_valid && out_ready.
- Back-to-back: an accept is allowed in the same cycle the previous output retires (full throughput for single-cycle ops).
- Flush:
  - Next cycle: out_valid=0, state=IDLE, counter=0.
  - A MUL in flight is discarded.
  - Any in_valid in the flush cycle is ignored (in_ready=0).
- Flush and retire in the same cycle: the flush wins and the output is dropped; the consumer has already sampled it.
- Reset mid-MUL: immediate return to reset values; no residual output.
- No stage modifies the PC directly; branch_taken and branch_target are consumed by the fetch unit only while out_valid=1.

Optional Feature:
- Macro EX_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, reset 0), registered with result.
  - ovf is set on signed two's-complement overflow of ADD/SUB.
  - For MUL, ovf is set when the high DATA_W bits of the full product are non-zero.
  - ovf is 0 for all other ops.
- Undefined: the port is absent and no overflow logic is built.

Decomposition:
- Package ex_pkg holds:
  - alu_op encodings: ALUOP_MEM=2'b00, ALUOP_BEQ=2'b01, ALUOP_R=2'b10.
  - funct codes: F_ADD=0, F_SUB=1, F_MUL=2.
  - ALU-control enum: ALU_ADD, ALU_SUB, ALU_MUL, ALU_NOP.
  - State enum: IDLE, MUL_BUSY.
- Sub-module ex_mul_pipe (parameters DATA_W, MUL_LAT) holds the staged product registers, a valid shift chain and a kill input driven by flush.

Test Plan:
1. ADD: alu_op=10, funct=0, rs=7, rt=5, alu_src=0, out_ready=1 -> one cycle later out_valid=1, result=12, zero=0.
2. BEQ: alu_op=01, branch=1, rs=rt=0x10, imm=3, pc=0x40 -> result=0, zero=1, branch_taken=1, branch_target=0x4C.
3. MUL: rs=6, rt=7, MUL_LAT=3 -> in_ready=0 for 2 cycles, out_valid=1 exactly 3 cycles after accept, result=42; hold out_ready=0 for 4 cycles -> outputs stable and in_ready=0.
4. Flush one cycle after a MUL accept -> no out_valid for that MUL; the next ADD (rs=1, imm=2, alu_src=1, alu_op=00) gives result=3 one cycle after accept.
5. Async reset pulsed mid-MUL between clock edges -> all outputs 0 immediately; in_ready=1 on the first edge after release.
6. EX_OVF_EN defined: ADD with 0x7FFFFFFF + 1 -> result=0x80000000, ovf=1; SUB 5-3 -> ovf=0; MUL 0x10000*0x10000 -> result=0, ovf=1.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, funct codes,
// ALU-control and FSM state enums.
package ex_pkg;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BEQ = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;

    localparam int F_ADD = 0;
    localparam int F_SUB = 1;
    localparam int F_MUL = 2;

    typedef enum logic [1:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_MUL,
        ALU_NOP
    } alu_ctl_e;

    typedef enum logic {
        IDLE,
        MUL_BUSY
    } state_e;

endpackage

// File: rtl/ex_mul_pipe.sv
// Staged unsigned multiplier with a valid shift chain and a kill input.
// EX_OVF_EN keeps the high product half to flag non-zero upper bits.
module ex_mul_pipe #(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              kill_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              vld_o,
`ifdef EX_OVF_EN
    output logic              hi_nz_o,
`endif
    output logic [DATA_W-1:0] prod_o
);

    localparam int ST = MUL_LAT - 1;
`ifdef EX_OVF_EN
    localparam int PW = 2 * DATA_W;
`else
    localparam int PW = DATA_W;
`endif

    logic [PW-1:0] prod_c;
    logic [PW-1:0] p_q [ST];
    logic [ST-1:0] v_q;

    assign prod_c = PW'(a_i) * PW'(b_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int i = 0; i < ST; i++) begin
                p_q[i] <= '0;
            end
        end else begin
            v_q[0] <= start_i && !kill_i;
            if (start_i) begin
                p_q[0] <= prod_c;
            end
            for (int i = 1; i < ST; i++) begin
                v_q[i] <= v_q[i-1] && !kill_i;
                p_q[i] <= p_q[i-1];
            end
        end
    end

    assign vld_o  = v_q[ST-1];
    assign prod_o = p_q[ST-1][DATA_W-1:0];
`ifdef EX_OVF_EN
    assign hi_nz_o = |p_q[ST-1][PW-1:DATA_W];
`endif

endmodule

// File: rtl/ex_stage_pipe.sv
// Execute stage with valid/ready on both sides, single-cycle ADD/SUB,
// pipelined MUL and BEQ resolve. EX_OVF_EN adds the ovf output.
module ex_stage_pipe
    import ex_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 3,
    parameter int FUNCT_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  rs,
    input  logic [DATA_W-1:0]  rt,
    input  logic [DATA_W-1:0]  imm,
    input  logic               alu_src,
    input  logic [1:0]         alu_op,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               branch,
    input  logic [DATA_W-1:0]  pc,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  result,
    output logic               zero,
    output logic               branch_taken,
`ifdef EX_OVF_EN
    output logic               ovf,
`endif
    output logic [DATA_W-1:0]  branch_target
);

    localparam int CNT_W = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    alu_ctl_e          ctl;
    logic [DATA_W-1:0] op2, sum, diff, alu_res, target_c;
    logic              zero_c, taken_c;
    logic              accept, acc_one, acc_mul, mul_done;
    logic              mul_vld;
    logic [DATA_W-1:0] mul_prod;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] result_q, target_q;
    logic              zero_q, taken_q;
`ifdef EX_OVF_EN
    logic              alu_ovf, mul_hi_nz, ovf_q;
`endif

    always_comb begin
        ctl = ALU_NOP;
        unique case (alu_op)
            ALUOP_MEM: ctl = ALU_ADD;
            ALUOP_BEQ: ctl = ALU_SUB;
            ALUOP_R: begin
                if (funct == FUNCT_W'(F_ADD)) ctl = ALU_ADD;
                else if (funct == FUNCT_W'(F_SUB)) ctl = ALU_SUB;
                else if (funct == FUNCT_W'(F_MUL)) ctl = ALU_MUL;
                else ctl = ALU_NOP;
            end
            default: ctl = ALU_NOP;
        endcase
    end

    // memory ops always address with rs + imm
    assign op2      = (alu_op == ALUOP_MEM || alu_src) ? imm : rt;
    assign sum      = rs + op2;
    assign diff     = rs - op2;
    assign zero_c   = (rs == op2);
    assign taken_c  = branch && zero_c;
    assign target_c = pc + (imm << 2);

    always_comb begin
        alu_res = '0;
        unique case (ctl)
            ALU_ADD: alu_res = sum;
            ALU_SUB: alu_res = diff;
            default: alu_res = '0;
        endcase
    end

`ifdef EX_OVF_EN
    always_comb begin
        alu_ovf = 1'b0;
        unique case (ctl)
            ALU_ADD: alu_ovf = (rs[DATA_W-1] == op2[DATA_W-1])
                            && (sum[DATA_W-1] != rs[DATA_W-1]);
            ALU_SUB: alu_ovf = (rs[DATA_W-1] != op2[DATA_W-1])
                            && (diff[DATA_W-1] != rs[DATA_W-1]);
            default: alu_ovf = 1'b0;
        endcase
    end
`endif

    assign accept   = in_valid && in_ready;
    assign acc_mul  = accept && (ctl == ALU_MUL);
    assign acc_one  = accept && (ctl != ALU_MUL);
    assign mul_done = (state_q == MUL_BUSY) && (cnt_q == CNT_W'(1));

    ex_mul_pipe #(
        .DATA_W  (DATA_W),
        .MUL_LAT (MUL_LAT)
    ) u_mul (
        .clk     (clk),
        .rst_n   (reset),
        .start_i (acc_mul),
        .kill_i  (flush),
        .a_i     (rs),
        .b_i     (op2),
        .vld_o   (mul_vld),
`ifdef EX_OVF_EN
        .hi_nz_o (mul_hi_nz),
`endif
        .prod_o  (mul_prod)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:     if (acc_mul) state_d = MUL_BUSY;
                MUL_BUSY: if (mul_done) state_d = IDLE;
                default:  state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready = reset && (state_q == IDLE)
                && (!out_valid_q || out_ready) && !flush;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (flush) begin
            cnt_q <= '0;
        end else if (acc_mul) begin
            cnt_q <= CNT_W'(MUL_LAT - 1);
        end else if (state_q == MUL_BUSY && cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // flush beats retire and completion; a retire without refill drops valid
    always_comb begin
        out_valid_d = out_valid_q;
        if (flush) out_valid_d = 1'b0;
        else if (acc_one) out_valid_d = 1'b1;
        else if (mul_done) out_valid_d = mul_vld;
        else if (out_ready) out_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            taken_q     <= 1'b0;
            target_q    <= '0;
`ifdef EX_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            if (acc_one) begin
                result_q <= alu_res;
                zero_q   <= zero_c;
                taken_q  <= taken_c;
                target_q <= target_c;
`ifdef EX_OVF_EN
                ovf_q    <= alu_ovf;
`endif
            end else if (acc_mul) begin
                zero_q   <= zero_c;
                taken_q  <= taken_c;
                target_q <= target_c;
            end else if (mul_done) begin
                result_q <= mul_prod;
`ifdef EX_OVF_EN
                ovf_q    <= mul_hi_nz;
`endif
            end
        end
    end

    assign out_valid     = out_valid_q;
    assign result        = result_q;
    assign zero          = zero_q;
    assign branch_taken  = taken_q;
    assign branch_target = target_q;
`ifdef EX_OVF_EN
    assign ovf           = ovf_q;
`endif

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Bench for ex_stage_pipe: directed cases plus random traffic against a
// transaction-level model. Define EX_OVF_EN to also check ovf.
module tb_ex_stage_pipe;

    localparam int W   = 32;
    localparam int LAT = 3;
    localparam int FW  = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_ready;
    logic [W-1:0]  rs, rt, imm, pc;
    logic          alu_src, branch, flush;
    logic [1:0]    alu_op;
    logic [FW-1:0] funct;
    logic          out_valid, out_ready;
    logic [W-1:0]  result, branch_target;
    logic          zero, branch_taken;
`ifdef EX_OVF_EN
    logic          ovf;
`endif

    always #5 clk = ~clk;

    ex_stage_pipe #(
        .DATA_W  (W),
        .MUL_LAT (LAT),
        .FUNCT_W (FW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .rs            (rs),
        .rt            (rt),
        .imm           (imm),
        .alu_src       (alu_src),
        .alu_op        (alu_op),
        .funct         (funct),
        .branch        (branch),
        .pc            (pc),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .zero          (zero),
        .branch_taken  (branch_taken),
`ifdef EX_OVF_EN
        .ovf           (ovf),
`endif
        .branch_target (branch_target)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // model: cycles left on a MUL, and the presented output
    int           busy;
    bit           mv;
    logic [W-1:0] m_res, m_tg, p_res, p_tg;
    bit           m_z, m_tk, m_ovf, p_z, p_tk, p_ovf;

    task automatic predict(output logic [W-1:0] r, output bit z,
                           output bit tk, output bit ov,
                           output logic [W-1:0] tg, output bit is_mul);
        logic [W-1:0] b;
        logic [63:0]  prod;
        longint       sa, sb, s;
        int           k;
        b    = (alu_op == 2'b00 || alu_src) ? imm : rt;
        sa   = longint'($signed(rs));
        sb   = longint'($signed(b));
        prod = {32'd0, rs} * {32'd0, b};
        if (alu_op == 2'b00) k = 0;
        else if (alu_op == 2'b01) k = 1;
        else if (alu_op == 2'b10 && funct < 3) k = int'(funct);
        else k = 3;
        is_mul = (k == 2);
        r = '0;
        ov = 1'b0;
        case (k)
            0: begin
                r = rs + b;
                s = sa + sb;
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            1: begin
                r = rs - b;
                s = sa - sb;
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            2: begin
                r = prod[31:0];
                ov = (prod[63:32] != 0);
            end
            default: begin
                r = '0;
                ov = 1'b0;
            end
        endcase
        z  = (rs == b);
        tk = branch && z;
        tg = pc + imm * 4;
    endtask

    // called just after a negedge with inputs already driven
    task automatic cycle();
        bit           exp_rdy, acc, z, tk, ov, is_mul;
        logic [W-1:0] r, tg;
        #1;
        exp_rdy = (busy == 0) && (!mv || out_ready) && !flush;
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid", out_valid, mv);
        if (mv) begin
            chk("result", result, m_res);
            chk("zero", zero, m_z);
            chk("taken", branch_taken, m_tk);
            chk("target", branch_target, m_tg);
`ifdef EX_OVF_EN
            chk("ovf", ovf, m_ovf);
`endif
        end
        acc = in_valid && exp_rdy;
        if (flush) begin
            mv = 0;
            busy = 0;
        end else if (acc) begin
            predict(r, z, tk, ov, tg, is_mul);
            if (is_mul) begin
                busy = LAT - 1;
                mv = 0;
                p_res = r; p_z = z; p_tk = tk; p_ovf = ov; p_tg = tg;
            end else begin
                mv = 1;
                m_res = r; m_z = z; m_tk = tk; m_ovf = ov; m_tg = tg;
            end
        end else if (busy > 0) begin
            busy--;
            if (busy == 0) begin
                mv = 1;
                m_res = p_res; m_z = p_z; m_tk = p_tk;
                m_ovf = p_ovf; m_tg = p_tg;
            end
        end else if (mv && out_ready) begin
            mv = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [1:0] op,
                         input logic [FW-1:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] im,
                         input bit src, input bit br,
                         input logic [W-1:0] p);
        in_valid = v; alu_op = op; funct = f; rs = a; rt = b;
        imm = im; alu_src = src; branch = br; pc = p;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 4))
            0: pick = $urandom_range(0, 15);
            1: pick = 32'h7FFF_FFFF;
            2: pick = 32'h8000_0000;
            3: pick = 32'h0001_0000;
            default: pick = $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(0, 2'b00, '0, '0, '0, '0, 0, 0, '0);
        busy = 0; mv = 0;
        @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 0);
        chk("rst_taken", branch_taken, 0);
        chk("rst_target", branch_target, 0);
        @(negedge clk);
        reset = 1'b1;

        // ADD
        drive(1, 2'b10, 6'd0, 7, 5, 0, 0, 0, 0);
        cycle();
        chk("add_valid", out_valid, 1);
        chk("add_res", result, 12);
        chk("add_zero", zero, 0);

        // BEQ
        drive(1, 2'b01, '0, 32'h10, 32'h10, 3, 0, 1, 32'h40);
        cycle();
        chk("beq_res", result, 0);
        chk("beq_zero", zero, 1);
        chk("beq_taken", branch_taken, 1);
        chk("beq_target", branch_target, 32'h4C);

        // MUL with backpressure on completion
        drive(1, 2'b10, 6'd2, 6, 7, 0, 0, 0, 0);
        cycle();
        in_valid = 0;
        chk("mul_busy1", in_ready, 0);
        cycle();
        chk("mul_busy2", in_ready, 0);
        chk("mul_early", out_valid, 0);
        out_ready = 0;
        cycle();
        chk("mul_valid", out_valid, 1);
        chk("mul_res", result, 42);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1;
            cycle();
            chk("bp_res", result, 42);
            chk("bp_ready", in_ready, 0);
        end
        out_ready = 1;
        in_valid = 0;
        cycle();

        // flush right after a MUL accept
        drive(1, 2'b10, 6'd2, 9, 9, 0, 0, 0, 0);
        cycle();
        drive(1, 2'b00, '0, 1, 0, 2, 1, 0, 0);
        flush = 1;
        cycle();
        flush = 0;
        chk("flush_valid", out_valid, 0);
        cycle();
        chk("post_flush_valid", out_valid, 1);
        chk("post_flush_res", result, 3);
        in_valid = 0;
        for (int i = 0; i < 4; i++) cycle();

`ifdef EX_OVF_EN
        drive(1, 2'b10, 6'd0, 32'h7FFF_FFFF, 1, 0, 0, 0, 0);
        cycle();
        chk("ovf_add_res", result, 32'h8000_0000);
        chk("ovf_add", ovf, 1);
        drive(1, 2'b10, 6'd1, 5, 3, 0, 0, 0, 0);
        cycle();
        chk("ovf_sub", ovf, 0);
        drive(1, 2'b10, 6'd2, 32'h10000, 32'h10000, 0, 0, 0, 0);
        cycle();
        in_valid = 0;
        cycle();
        cycle();
        chk("ovf_mul_res", result, 0);
        chk("ovf_mul", ovf, 1);
        cycle();
`endif

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) < 7, 2'($urandom),
                  ($urandom_range(0, 7) == 0) ? 6'd5 : 6'($urandom_range(0, 3)),
                  pick(), pick(), pick(), 1'($urandom), 1'($urandom),
                  $urandom);
            if ($urandom_range(0, 3) == 0) rt = rs;
            out_ready = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 19) == 0;
            cycle();
        end
        flush = 0;
        out_ready = 1;
        in_valid = 0;
        for (int i = 0; i < LAT + 1; i++) cycle();

        // async reset in the middle of a MUL
        drive(1, 2'b10, 6'd2, 3, 4, 1, 0, 0, 32'h100);
        cycle();
        in_valid = 0;
        #2;
        reset = 1'b0;
        #1;
        chk("amid_valid", out_valid, 0);
        chk("amid_result", result, 0);
        chk("amid_zero", zero, 0);
        chk("amid_taken", branch_taken, 0);
        chk("amid_target", branch_target, 0);
        chk("amid_ready", in_ready, 0);
        #1;
        reset = 1'b1;
        busy = 0; mv = 0;
        @(posedge clk);
        #1;
        chk("arel_ready", in_ready, 1);
        chk("arel_valid", out_valid, 0);
        @(negedge clk);
        for (int i = 0; i < LAT + 1; i++) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
